// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD host command sequencer: command codes,
// image/window geometry constants, sequencer state encoding and origin helpers.
package lcd_pkg;

    typedef enum logic [2:0] {
        CMD_REFRESH = 3'd0,
        CMD_LOAD    = 3'd1,
        CMD_RIGHT   = 3'd2,
        CMD_LEFT    = 3'd3,
        CMD_UP      = 3'd4,
        CMD_DOWN    = 3'd5
    } lcd_cmd_t;

    localparam int IMG_BYTES = 36;
    localparam int WIN_BYTES = 9;
    localparam int GRID_W    = 6;
    localparam int ORG_MAX   = 3;
    localparam int ORG_RESET = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_LOAD,
        ST_COLLECT,
        ST_WAIT_IDLE
    } state_t;

    // One saturating step of a window origin coordinate within 0..ORG_MAX.
    function automatic logic [2:0] org_step(input logic [2:0] v, input logic inc);
        if (inc) begin
            return (v >= 3'(ORG_MAX)) ? 3'(ORG_MAX) : v + 3'd1;
        end
        return (v == 3'd0) ? 3'd0 : v - 3'd1;
    endfunction

    // Raster index of the top-left window byte for a given origin.
    function automatic int win_base(input logic [2:0] x, input logic [2:0] y);
        return int'(y) * GRID_W + int'(x);
    endfunction

endpackage

// File: rtl/lcd_host_seq_if.sv
// Command/data link between the host sequencer (master) and the LCD
// controller (slave).
interface lcd_host_seq_if;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic [7:0] datain;
    logic       busy;
    logic [7:0] dataout;
    logic       output_valid;

    modport master (
        output cmd, cmd_valid, datain,
        input  busy, dataout, output_valid
    );

    modport slave (
        input  cmd, cmd_valid, datain,
        output busy, dataout, output_valid
    );
endinterface

// File: rtl/lcd_origin_shadow.sv
// Tracks the controller's 3x3 window origin from accepted commands, clamped
// to 0..ORG_MAX on both axes.
module lcd_origin_shadow
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       upd,
    input  logic [2:0] cmd,
    output logic [2:0] org_x,
    output logic [2:0] org_y
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            org_x <= 3'(ORG_RESET);
            org_y <= 3'(ORG_RESET);
        end else if (upd) begin
            case (cmd)
                CMD_LOAD: begin
                    org_x <= 3'(ORG_RESET);
                    org_y <= 3'(ORG_RESET);
                end
                CMD_RIGHT: org_x <= org_step(org_x, 1'b1);
                CMD_LEFT:  org_x <= org_step(org_x, 1'b0);
                CMD_UP:    org_y <= org_step(org_y, 1'b0);
                CMD_DOWN:  org_y <= org_step(org_y, 1'b1);
                default:   ;
            endcase
        end
    end

endmodule

// File: rtl/lcd_host_seq.sv
// Host-side command sequencer for the 6x6-image / 3x3-window LCD controller.
// Optional origin shadow outputs (org_x/org_y) under LCD_HOST_SHADOW_EN.
module lcd_host_seq
    import lcd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [2:0]        req_cmd,
    output logic              req_ready,
    output logic [5:0]        img_addr,
    input  logic [7:0]        img_data,
    lcd_host_seq_if.master    lcd,
    output logic [7:0]        win_data,
    output logic [3:0]        win_idx,
    output logic              win_valid,
    output logic              done,
    output logic              cmd_err,
    output logic              timeout
`ifdef LCD_HOST_SHADOW_EN
    ,
    output logic [2:0]        org_x,
    output logic [2:0]        org_y
`endif
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state_reg;
    logic [2:0]        cmd_reg;
    logic              cmd_valid_reg;
    logic [3:0]        cap_cnt_reg;
    logic [WD_W-1:0]   wd_cnt_reg;
    logic              wd_expired;

    assign lcd.cmd       = cmd_reg;
    assign lcd.cmd_valid = cmd_valid_reg;
    // Image memory is read combinationally, so the byte for img_addr is forwarded directly.
    assign lcd.datain    = (state_reg == ST_LOAD) ? img_data : 8'd0;
    assign wd_expired    = (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            req_ready     <= 1'b1;
            cmd_reg       <= 3'd0;
            cmd_valid_reg <= 1'b0;
            img_addr      <= 6'd0;
            cap_cnt_reg   <= 4'd0;
            wd_cnt_reg    <= '0;
            win_data      <= 8'd0;
            win_idx       <= 4'd0;
            win_valid     <= 1'b0;
            done          <= 1'b0;
            cmd_err       <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
            timeout   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        if (req_cmd <= CMD_DOWN) begin
                            cmd_reg       <= req_cmd;
                            cmd_valid_reg <= 1'b1;
                            req_ready     <= 1'b0;
                            state_reg     <= ST_ISSUE;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!lcd.busy) begin
                        cmd_valid_reg <= 1'b0;
                        if (cmd_reg == CMD_LOAD) begin
                            img_addr  <= 6'd0;
                            state_reg <= ST_LOAD;
                        end else begin
                            cap_cnt_reg <= 4'd0;
                            wd_cnt_reg  <= '0;
                            state_reg   <= ST_COLLECT;
                        end
                    end
                end
                ST_LOAD: begin
                    if (img_addr == 6'(IMG_BYTES - 1)) begin
                        img_addr    <= 6'd0;
                        cap_cnt_reg <= 4'd0;
                        wd_cnt_reg  <= '0;
                        state_reg   <= ST_COLLECT;
                    end else begin
                        img_addr <= img_addr + 6'd1;
                    end
                end
                ST_COLLECT: begin
                    // Abort takes priority over a capture landing on the last allowed cycle.
                    if (wd_expired) begin
                        timeout   <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 1'b1;
                        if (lcd.output_valid) begin
                            win_data    <= lcd.dataout;
                            win_idx     <= cap_cnt_reg;
                            win_valid   <= 1'b1;
                            cap_cnt_reg <= cap_cnt_reg + 4'd1;
                            if (cap_cnt_reg == 4'(WIN_BYTES - 1)) begin
                                state_reg <= ST_WAIT_IDLE;
                            end
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (wd_expired) begin
                        timeout   <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else if (!lcd.busy) begin
                        done      <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef LCD_HOST_SHADOW_EN
    logic cmd_accept;
    assign cmd_accept = (state_reg == ST_ISSUE) && !lcd.busy;

    lcd_origin_shadow u_shadow (
        .clk   (clk),
        .reset (reset),
        .upd   (cmd_accept),
        .cmd   (cmd_reg),
        .org_x (org_x),
        .org_y (org_y)
    );
`endif

endmodule

// File: tb/tb_lcd_host_seq.sv
// Testbench for lcd_host_seq with a behavioural LCD controller model; checks
// org_x/org_y as well when built with LCD_HOST_SHADOW_EN.
module tb_lcd_host_seq;
    import lcd_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [2:0] req_cmd;
    logic       req_ready;
    logic [5:0] img_addr;
    logic [7:0] img_data;
    logic [7:0] win_data;
    logic [3:0] win_idx;
    logic       win_valid, done, cmd_err, timeout;
`ifdef LCD_HOST_SHADOW_EN
    logic [2:0] org_x, org_y;
`endif

    always #5 clk = ~clk;

    lcd_host_seq_if bus ();

    logic [7:0] img_mem [0:35];
    assign img_data = (img_addr < 6'd36) ? img_mem[img_addr] : 8'd0;

    lcd_host_seq #(.TIMEOUT_CYCLES(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_cmd   (req_cmd),
        .req_ready (req_ready),
        .img_addr  (img_addr),
        .img_data  (img_data),
        .lcd       (bus),
        .win_data  (win_data),
        .win_idx   (win_idx),
        .win_valid (win_valid),
        .done      (done),
        .cmd_err   (cmd_err),
        .timeout   (timeout)
`ifdef LCD_HOST_SHADOW_EN
        ,
        .org_x     (org_x),
        .org_y     (org_y)
`endif
    );

    // ---------------- controller model ----------------
    logic       ctrl_upd;
    logic [2:0] c_ox, c_oy;
    assign ctrl_upd = bus.cmd_valid && !bus.busy;

    lcd_origin_shadow u_ctrl_org (
        .clk   (clk),
        .reset (reset),
        .upd   (ctrl_upd),
        .cmd   (bus.cmd),
        .org_x (c_ox),
        .org_y (c_oy)
    );

    int         ov_count  = 9;
    logic       busy_hold = 1'b0;
    int         acc_cnt   = 0;
    int         acc_edge  = 0;
    int         cyc       = 0;
    logic [7:0] ctrl_img [0:35];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : ctrl_model
        logic [2:0] c;
        bit         aborted;
        int         base;
        for (int k = 0; k < 36; k++) ctrl_img[k] = 8'd0;
        bus.busy = 1'b0;
        bus.output_valid = 1'b0;
        bus.dataout = 8'd0;
        forever begin
            @(negedge clk);
            bus.busy = busy_hold;
            if (!reset && bus.cmd_valid && !bus.busy) begin
                c = bus.cmd;
                acc_cnt++;
                acc_edge = cyc + 1;
                aborted = 1'b0;
                @(posedge clk);
                #1 bus.busy = 1'b1;
                if (c == CMD_LOAD) begin
                    for (int k = 0; k < IMG_BYTES; k++) begin
                        @(negedge clk);
                        if (reset) begin
                            aborted = 1'b1;
                            break;
                        end
                        ctrl_img[k] = bus.datain;
                    end
                    if (!aborted) begin
                        @(posedge clk);
                        #1;
                    end
                end else begin
                    @(posedge clk);
                    #1;
                end
                if (!aborted) begin
                    base = win_base(c_ox, c_oy);
                    for (int i = 0; i < ov_count; i++) begin
                        bus.output_valid = 1'b1;
                        bus.dataout = ctrl_img[base + (i / 3) * GRID_W + (i % 3)];
                        @(posedge clk);
                        #1;
                    end
                end
                bus.output_valid = 1'b0;
                bus.busy = 1'b0;
                bus.dataout = 8'd0;
            end
        end
    end

    // ---------------- output monitor ----------------
    typedef struct packed {
        logic [3:0] idx;
        logic [7:0] data;
    } cap_t;

    cap_t cap_q [$];
    int   n_done, n_err, n_to, n_cv, to_cyc;
    logic err_rdy, done_rdy;

    initial forever begin
        @(negedge clk);
        if (win_valid) cap_q.push_back({win_idx, win_data});
        if (done) begin
            n_done++;
            done_rdy = req_ready;
        end
        if (cmd_err) begin
            n_err++;
            err_rdy = req_ready;
        end
        if (timeout) begin
            n_to++;
            to_cyc = cyc;
        end
        if (bus.cmd_valid) n_cv++;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: image snapshot at the last load plus a clamped origin.
    logic [7:0] ref_img [0:35];
    int         ref_x = 2, ref_y = 2;
    logic [7:0] exp_win [0:8];
    int         acc0;

    task automatic ref_apply(input logic [2:0] c);
        case (c)
            3'd1: begin
                for (int k = 0; k < 36; k++) ref_img[k] = img_mem[k];
                ref_x = 2;
                ref_y = 2;
            end
            3'd2: ref_x = (ref_x < 3) ? ref_x + 1 : 3;
            3'd3: ref_x = (ref_x > 0) ? ref_x - 1 : 0;
            3'd4: ref_y = (ref_y > 0) ? ref_y - 1 : 0;
            3'd5: ref_y = (ref_y < 3) ? ref_y + 1 : 3;
            default: ;
        endcase
    endtask

    task automatic fill_exp_from_ref();
        for (int i = 0; i < 9; i++) exp_win[i] = ref_img[(ref_y + i / 3) * 6 + ref_x + i % 3];
    endtask

    task automatic run_req(input logic [2:0] c, input int hold);
        int waitc;
        cap_q.delete();
        n_done = 0; n_err = 0; n_to = 0; n_cv = 0;
        err_rdy = 1'b0; done_rdy = 1'b1;
        acc0 = acc_cnt;
        waitc = 0;
        while (req_ready !== 1'b1 && waitc < 20) begin
            @(posedge clk);
            #1 waitc++;
        end
        chk("req_ready_before_req", req_ready, 1);
        busy_hold = (hold > 0);
        req_valid = 1'b1;
        req_cmd = c;
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1 busy_hold = 1'b0;
        end
        waitc = 0;
        while (n_done == 0 && n_to == 0 && n_err == 0 && waitc < 300) begin
            @(posedge clk);
            #1 waitc++;
        end
        chk("req_completes", (n_done + n_to + n_err) > 0, 1);
        repeat (2) @(posedge clk);
        #1;
        $display("req cmd=%0d hold=%0d caps=%0d done=%0d err=%0d timeout=%0d cmd_valid_cycles=%0d",
                 c, hold, cap_q.size(), n_done, n_err, n_to, n_cv);
    endtask

    task automatic check_legal();
        chk("cap_count", cap_q.size(), 9);
        if (cap_q.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                chk("win_idx", cap_q[i].idx, i);
                chk("win_data", cap_q[i].data, exp_win[i]);
            end
        end
        chk("done_count", n_done, 1);
        chk("timeout_count", n_to, 0);
        chk("accept_count", acc_cnt - acc0, 1);
        chk("ready_low_in_done", done_rdy, 0);
`ifdef LCD_HOST_SHADOW_EN
        chk("org_x", org_x, ref_x);
        chk("org_y", org_y, ref_y);
`endif
    endtask

    task automatic check_illegal();
        chk("cmd_err_count", n_err, 1);
        chk("illegal_cmd_valid_cycles", n_cv, 0);
        chk("illegal_accepts", acc_cnt - acc0, 0);
        chk("ready_in_err_cycle", err_rdy, 1);
        chk("illegal_done", n_done, 0);
    endtask

    task automatic check_load_bytes();
        for (int k = 0; k < 36; k++) chk("load_byte", ctrl_img[k], img_mem[k]);
    endtask

    function automatic logic [63:0] out_vec();
        return {30'd0, img_addr, bus.datain, bus.cmd, bus.cmd_valid, win_data, win_idx,
                win_valid, done, cmd_err, timeout};
    endfunction

    typedef struct {
        logic [2:0] cmd;
        bit         err;
        int         first;
        int         ox;
        int         oy;
    } vec_t;

    vec_t tbl [16];

    initial begin
        tbl[0]  = '{3'd1, 1'b0, 24, 2, 2};
        tbl[1]  = '{3'd2, 1'b0, 25, 3, 2};
        tbl[2]  = '{3'd2, 1'b0, 25, 3, 2};
        tbl[3]  = '{3'd5, 1'b0, 31, 3, 3};
        tbl[4]  = '{3'd0, 1'b0, 31, 3, 3};
        tbl[5]  = '{3'd5, 1'b0, 31, 3, 3};
        tbl[6]  = '{3'd3, 1'b0, 30, 2, 3};
        tbl[7]  = '{3'd4, 1'b0, 24, 2, 2};
        tbl[8]  = '{3'd4, 1'b0, 18, 2, 1};
        tbl[9]  = '{3'd4, 1'b0, 12, 2, 0};
        tbl[10] = '{3'd4, 1'b0, 12, 2, 0};
        tbl[11] = '{3'd3, 1'b0, 11, 1, 0};
        tbl[12] = '{3'd3, 1'b0, 10, 0, 0};
        tbl[13] = '{3'd3, 1'b0, 10, 0, 0};
        tbl[14] = '{3'd7, 1'b1, 0, 0, 0};
        tbl[15] = '{3'd6, 1'b1, 0, 0, 0};

        for (int k = 0; k < 36; k++) img_mem[k] = 8'(k + 10);
        req_valid = 1'b0;
        req_cmd = 3'd0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", out_vec(), 0);
        chk("reset_req_ready", req_ready, 1);
`ifdef LCD_HOST_SHADOW_EN
        chk("reset_org_x", org_x, 2);
        chk("reset_org_y", org_y, 2);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1 chk("idle_req_ready", req_ready, 1);

        // Directed table: load, shifts with clamping, refresh, illegal codes.
        for (int v = 0; v < 16; v++) begin
            run_req(tbl[v].cmd, 0);
            if (tbl[v].err) begin
                check_illegal();
            end else begin
                ref_apply(tbl[v].cmd);
                chk("table_ref_x", ref_x, tbl[v].ox);
                chk("table_ref_y", ref_y, tbl[v].oy);
                for (int i = 0; i < 9; i++) exp_win[i] = 8'(tbl[v].first + (i / 3) * 6 + i % 3);
                check_legal();
                if (tbl[v].cmd == CMD_LOAD) check_load_bytes();
            end
        end

        // Busy held for 5 cycles while the command is presented.
        run_req(CMD_REFRESH, 5);
        chk("busy_hold_cmd_valid_cycles", n_cv, 6);
        fill_exp_from_ref();
        check_legal();

        // Watchdog: controller returns only 4 bytes.
        ov_count = 4;
        run_req(CMD_REFRESH, 0);
        ov_count = 9;
        chk("wd_timeout_count", n_to, 1);
        chk("wd_done_count", n_done, 0);
        chk("wd_cap_count", cap_q.size(), 4);
        chk("wd_latency", to_cyc - acc_edge, 64);
        chk("wd_ready_after", req_ready, 1);

        // Reset at LOAD cycle 20, then a fresh load must stream from byte 0.
        run_req(CMD_REFRESH, 0);
        fill_exp_from_ref();
        check_legal();
        req_valid = 1'b1;
        req_cmd = CMD_LOAD;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (21) @(posedge clk);
        #1 chk("addr_before_reset", img_addr, 20);
        chk("datain_before_reset", bus.datain, 30);
        reset = 1'b1;
        #1 chk("midload_reset_outputs", out_vec(), 0);
        chk("midload_reset_ready", req_ready, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        ref_x = 2;
        ref_y = 2;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 36; k++) img_mem[k] = 8'(100 + k);
        run_req(CMD_LOAD, 0);
        ref_apply(CMD_LOAD);
        fill_exp_from_ref();
        check_legal();
        check_load_bytes();

        // Randomized requests against the reference model.
        for (int r = 0; r < 30; r++) begin
            logic [2:0] c;
            int hold;
            c = 3'($urandom_range(0, 7));
            hold = $urandom_range(0, 3);
            if (c == CMD_LOAD) begin
                for (int k = 0; k < 36; k++) img_mem[k] = 8'($urandom_range(0, 255));
            end
            run_req(c, hold);
            if (c > 3'd5) begin
                check_illegal();
            end else begin
                ref_apply(c);
                fill_exp_from_ref();
                check_legal();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
